// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: word type, arbiter FSM states and grant sides.
// Also holds the arbitration decision so both arbitration modes use the same rule.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        DACC,
        IACC,
        DRESP,
        IRESP
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    // Data side wins unless rotation is on, both sides are pending and data had the last turn.
    function automatic logic pick_data(
        input logic   d_req,
        input logic   i_req,
        input logic   rr_en,
        input grant_t last
    );
        return d_req & (~rr_en | ~i_req | (last == GRANT_I));
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Memory-side responder for the caches request bus.
// Serialises instruction reads and data reads/writes onto one single-ported RAM and
// answers each request with a one-cycle low pulse on iwait/dwait plus iload/dload.
// Build option ARB_RR_EN: when defined, contention alternates between the two sides
// (data first after reset); when undefined, data always wins.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and launch the next RAM access
// DACC  | data access on the RAM, strobes held until ram_ready
// IACC  | instruction read on the RAM, strobes held until ram_ready
// DRESP | dwait low for this cycle, dload valid
// IRESP | iwait low for this cycle, iload valid
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       d_req;
    logic       grant_d;
    logic       grant_i;

    assign d_req = dREN | dWEN;

`ifdef ARB_RR_EN
    grant_t last_grant;

    // Remember which side was answered last so contention can alternate.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= GRANT_I;
        end else if (state == DRESP) begin
            last_grant <= GRANT_D;
        end else if (state == IRESP) begin
            last_grant <= GRANT_I;
        end
    end

    assign grant_d = pick_data(d_req, iREN, 1'b1, last_grant);
`else
    assign grant_d = pick_data(d_req, iREN, 1'b0, GRANT_I);
`endif

    assign grant_i = iREN & ~grant_d;

    // The response pulses are decoded straight from the state register, so they are glitch-free
    // and can never be low together.
    assign iwait = (state != IRESP);
    assign dwait = (state != DRESP);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = DACC;
                end else if (grant_i) begin
                    state_nxt = IACC;
                end
            end
            DACC: begin
                if (ram_ready) begin
                    state_nxt = DRESP;
                end
            end
            IACC: begin
                if (ram_ready) begin
                    state_nxt = IRESP;
                end
            end
            DRESP:   state_nxt = IDLE;
            IRESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM strobes/address/data launch in IDLE and stay frozen until ram_ready; read data is
    // captured on completion and held until the next access of the same side finishes.
    // A simultaneous dREN/dWEN is treated as a write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            iload     <= '0;
            dload     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        ram_addr  <= daddr;
                        ram_store <= dstore;
                        ram_wen   <= dWEN;
                        ram_ren   <= dREN & ~dWEN;
                    end else if (grant_i) begin
                        ram_addr  <= iaddr;
                        ram_ren   <= 1'b1;
                        ram_wen   <= 1'b0;
                    end
                end
                DACC: begin
                    if (ram_ready) begin
                        dload   <= ram_load;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                    end
                end
                IACC: begin
                    if (ram_ready) begin
                        iload   <= ram_load;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
